// File: rtl/pid_seq_fp_pkg.sv
// pid_seq_pkg: shared state encoding, FP constants and default latencies for pid_seq_fp
package pid_seq_pkg;
  typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, ADD0, ADD1, ADD2, DONE} state_t;
  localparam logic [63:0] FP_ZERO = 64'h0;
  localparam logic [63:0] FP_ONE = 64'h3FF0000000000000;
  localparam int MULT_LAT_DEF = 5;
  localparam int ADD_LAT_DEF = 7;
endpackage

// File: rtl/pid_seq_fp_if.sv
// pid_seq_fp_if: operand/result bus to the shared FP multiplier and adder
interface pid_seq_fp_if;
  logic [63:0] mult_a, mult_b, mult_res;
  logic [63:0] add_a, add_b, add_res;
  logic add_sub;
  modport master (output mult_a, mult_b, add_a, add_b, add_sub, input mult_res, add_res);
  modport slave (input mult_a, mult_b, add_a, add_b, add_sub, output mult_res, add_res);
endinterface

// File: rtl/pid_seq_fp_slot.sv
// fp_op_slot: times one FP operation slot; capture at issue+LAT, done at issue+LAT+1
module fp_op_slot #(
  parameter int MULT_LAT = 5,
  parameter int ADD_LAT = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic add,
  output logic capture,
  output logic done
);
  logic [3:0] cnt;
  logic [3:0] lat;
  assign lat = add ? 4'(ADD_LAT) : 4'(MULT_LAT);
  assign capture = (cnt != 4'd0) && (cnt == lat);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= 4'd0;
      done <= 1'b0;
    end else begin
      done <= capture;
      cnt <= start ? 4'd1 : (capture || cnt == 4'd0) ? 4'd0 : cnt + 4'd1;
    end
endmodule

// File: rtl/pid_seq_fp.sv
// pid_seq_fp: sequences u0 = u1 + a0*e0 + a1*e1 + a2*e2 over one shared FP multiplier and adder
module pid_seq_fp
  import pid_seq_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int ADD_LAT = ADD_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] e0,
  input  logic        e0ready,
  input  logic [63:0] a0,
  input  logic [63:0] a1,
  input  logic [63:0] a2,
  input  logic        clr,
  pid_seq_fp_if.master fpu,
  output logic [63:0] u0,
  output logic        u0ready,
  output logic        busy,
  output logic        overrun
);
  state_t state;
  logic [63:0] e0r, a1r, a2r, e1, e2, u1, p0, p1, p2;
  logic go, capture, done, start, add;
  assign busy = (state != IDLE);
  assign add = state inside {ADD0, ADD1, ADD2};
  // each slot after the first is kicked off by the previous slot's done pulse
  assign start = go | (done & (state != IDLE) & (state != DONE));
  assign fpu.add_sub = 1'b1;
  fp_op_slot #(.MULT_LAT(MULT_LAT), .ADD_LAT(ADD_LAT)) u_slot (
    .clk(clk), .rst_n(rst_n), .start(start), .add(add), .capture(capture), .done(done)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      {e0r, a1r, a2r, e1, e2, u1, p0, p1, p2, u0} <= {10{FP_ZERO}};
      {fpu.mult_a, fpu.mult_b, fpu.add_a, fpu.add_b} <= {4{FP_ZERO}};
      u0ready <= 1'b0;
      overrun <= 1'b0;
      go <= 1'b0;
    end else begin
      go <= 1'b0;
      u0ready <= 1'b0;
      if (e0ready && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE:
          if (e0ready) begin
            e0r <= e0;
            a1r <= a1;
            a2r <= a2;
            fpu.mult_a <= a0;
            fpu.mult_b <= e0;
            go <= 1'b1;
            state <= MUL0;
          end else if (clr) begin
            e1 <= FP_ZERO;
            e2 <= FP_ZERO;
            u1 <= FP_ZERO;
          end
        MUL0:
          if (capture) begin
            p0 <= fpu.mult_res;
            fpu.mult_a <= a1r;
            fpu.mult_b <= e1;
            state <= MUL1;
          end
        MUL1:
          if (capture) begin
            p1 <= fpu.mult_res;
            fpu.mult_a <= a2r;
            fpu.mult_b <= e2;
            state <= MUL2;
          end
        MUL2:
          if (capture) begin
            p2 <= fpu.mult_res;
            fpu.mult_a <= FP_ZERO;
            fpu.mult_b <= FP_ZERO;
            fpu.add_a <= u1;
            fpu.add_b <= p0;
            state <= ADD0;
          end
        ADD0:
          if (capture) begin
            fpu.add_a <= fpu.add_res;
            fpu.add_b <= p1;
            state <= ADD1;
          end
        ADD1:
          if (capture) begin
            fpu.add_a <= fpu.add_res;
            fpu.add_b <= p2;
            state <= ADD2;
          end
        ADD2:
          if (capture) begin
            u0 <= fpu.add_res;
            fpu.add_a <= FP_ZERO;
            fpu.add_b <= FP_ZERO;
            u0ready <= 1'b1;
            state <= DONE;
          end
        default: begin
          e2 <= e1;
          e1 <= e0r;
          u1 <= u0;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_pid_seq_fp.sv
// tb_pid_seq_fp: directed checks of pid_seq_fp against behavioural fixed-latency FP units
module tb_pid_seq_fp;
  import pid_seq_pkg::*;
  logic clk, rst_n, e0ready, clr, u0ready, busy, overrun;
  logic [63:0] e0, a0, a1, a2, u0;
  int checks = 0, errors = 0;
  pid_seq_fp_if fpu ();
  pid_seq_fp dut (
    .clk(clk), .rst_n(rst_n), .e0(e0), .e0ready(e0ready), .a0(a0), .a1(a1), .a2(a2),
    .clr(clr), .fpu(fpu), .u0(u0), .u0ready(u0ready), .busy(busy), .overrun(overrun)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  logic [63:0] mp [MULT_LAT_DEF];
  logic [63:0] ap [ADD_LAT_DEF];
  always @(posedge clk) begin
    mp[0] <= $realtobits($bitstoreal(fpu.mult_a) * $bitstoreal(fpu.mult_b));
    ap[0] <= $realtobits($bitstoreal(fpu.add_a) + $bitstoreal(fpu.add_b));
    for (int i = 1; i < MULT_LAT_DEF; i++) mp[i] <= mp[i-1];
    for (int i = 1; i < ADD_LAT_DEF; i++) ap[i] <= ap[i-1];
  end
  assign fpu.mult_res = mp[MULT_LAT_DEF-1];
  assign fpu.add_res = ap[ADD_LAT_DEF-1];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic run(input int id, input real e, input real c0, input real c1, input real c2,
                     input logic cl, input int inj, input int rst_at,
                     input logic [63:0] exp_u0, input int exp_p, input logic exp_ov);
    logic [63:0] ma [51], mb [51], aa [51], ab [51], u0p;
    logic bz [51];
    int pulses, first, unst, idl, sub_bad, s;
    pulses = 0; first = 0; unst = 0; idl = 0; sub_bad = 0; u0p = 64'h0;
    @(negedge clk);
    e0 = $realtobits(e); a0 = $realtobits(c0); a1 = $realtobits(c1); a2 = $realtobits(c2);
    clr = cl; e0ready = 1'b1;
    @(negedge clk);
    e0ready = 1'b0; clr = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      ma[k] = fpu.mult_a; mb[k] = fpu.mult_b; aa[k] = fpu.add_a; ab[k] = fpu.add_b; bz[k] = busy;
      if (u0ready) begin
        pulses++;
        if (first == 0) begin first = k; u0p = u0; end
      end
      if (!fpu.add_sub) sub_bad++;
      if (k == inj) begin
        e0 = $realtobits(3.0); a0 = $realtobits(4.0); e0ready = 1'b1;
      end
      if (k == inj + 1) e0ready = 1'b0;
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk($sformatf("s%0d_rst_u0", id), u0, 64'h0);
        chk($sformatf("s%0d_rst_flags", id), {u0ready, busy, overrun}, 3'b000);
        chk($sformatf("s%0d_rst_ops", id), fpu.mult_a | fpu.mult_b | fpu.add_a | fpu.add_b, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
      end
      @(negedge clk);
    end
    for (int k = 1; k <= 43; k++)
      if (k <= 18) begin
        s = 1 + 6 * ((k - 1) / 6);
        if (ma[k] !== ma[s] || mb[k] !== mb[s]) unst++;
        if ((aa[k] | ab[k]) !== 64'h0) idl++;
      end else if (k <= 42) begin
        s = 19 + 8 * ((k - 19) / 8);
        if (aa[k] !== aa[s] || ab[k] !== ab[s]) unst++;
        if ((ma[k] | mb[k]) !== 64'h0) idl++;
      end else if ((ma[k] | mb[k] | aa[k] | ab[k]) !== 64'h0) idl++;
    chk($sformatf("s%0d_pulses", id), pulses, exp_p);
    chk($sformatf("s%0d_strobe_cycle", id), first, exp_p != 0 ? 43 : 0);
    chk($sformatf("s%0d_u0_at_strobe", id), u0p, exp_p != 0 ? exp_u0 : 64'h0);
    chk($sformatf("s%0d_u0_held", id), u0, exp_u0);
    chk($sformatf("s%0d_overrun", id), overrun, exp_ov);
    chk($sformatf("s%0d_add_sub", id), sub_bad, 0);
    if (rst_at == 0) begin
      chk($sformatf("s%0d_busy", id), {bz[1], bz[43], bz[44]}, 3'b110);
      chk($sformatf("s%0d_stable", id), unst, 0);
      chk($sformatf("s%0d_idle_ops", id), idl, 0);
    end
  endtask
  initial begin
    rst_n = 1'b0; e0ready = 1'b0; clr = 1'b0;
    e0 = 64'h0; a0 = 64'h0; a1 = 64'h0; a2 = 64'h0;
    repeat (3) @(negedge clk);
    chk("reset_u0", u0, 64'h0);
    chk("reset_flags", {u0ready, busy, overrun, fpu.add_sub}, 4'b0001);
    chk("reset_ops", fpu.mult_a | fpu.mult_b | fpu.add_a | fpu.add_b, 64'h0);
    rst_n = 1'b1;
    run(1, 2.0, 1.0, 0.0, 0.0, 1'b0, 0, 0, 64'h4000000000000000, 1, 1'b0);
    run(2, 1.0, 1.0, 1.0, 0.0, 1'b0, 0, 0, 64'h4014000000000000, 1, 1'b0);
    run(3, 0.0, 0.0, 0.0, 1.0, 1'b0, 0, 0, 64'h401C000000000000, 1, 1'b0);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    run(4, 1.0, 1.0, 1.0, 1.0, 1'b0, 0, 0, 64'h3FF0000000000000, 1, 1'b0);
    run(5, 0.0, 1.0, 1.0, 0.0, 1'b1, 0, 0, 64'h4000000000000000, 1, 1'b0);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    run(6, 2.0, 1.0, 0.0, 0.0, 1'b0, 20, 0, 64'h4000000000000000, 1, 1'b1);
    run(7, 2.0, 1.0, 1.0, 1.0, 1'b0, 0, 25, 64'h0, 0, 1'b0);
    run(8, 2.0, 1.0, 1.0, 1.0, 1'b0, 0, 0, 64'h4000000000000000, 1, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
